pipeline_stat_monitor: RTL and testbench



---
 rtl/pipeline_stat_monitor_pkg.sv | 22 ++
 rtl/pipeline_stat_monitor_counter.sv | 27 ++
 rtl/pipeline_stat_monitor.sv | 95 +++++++++
 tb/tb_pipeline_stat_monitor.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_stat_monitor_pkg.sv
// Shared types for the pipeline statistics monitor: display-source encodings
// and default counter width.
package pipeline_stat_monitor_pkg;

  localparam int CNT_BITS_DEFAULT = 32;
  localparam int MODE_COUNT       = 5;

  typedef enum logic [2:0] {
    SHOW_SYS    = 3'd0,
    SHOW_TOTAL  = 3'd1,
    SHOW_COND   = 3'd2,
    SHOW_UNCOND = 3'd3,
    SHOW_STALL  = 3'd4
  } mode_e;

  // Round-robin successor; anything past the last source goes back to SHOW_SYS.
  function automatic mode_e next_mode(input mode_e m);
    if (int'(m) >= MODE_COUNT - 1) return SHOW_SYS;
    return mode_e'(m + 3'd1);
  endfunction

endpackage

// File: rtl/pipeline_stat_monitor_counter.sv
// Wrapping statistic counter with synchronous clear that beats the enable.
module stat_counter #(
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  output logic [CNT_BITS-1:0] count
);

  logic [CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + CNT_BITS'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stat_monitor.sv
// Execution statistics and seven-segment source selector that sits behind the
// pipelined core; a push button cycles which registered word is displayed.
module pipeline_stat_monitor
  import pipeline_stat_monitor_pkg::*;
#(
  parameter int CNT_BITS    = CNT_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pcen,
  input  logic                jmp,
  input  logic                branch_taken,
  input  logic                bubble,
  input  logic                sys_show,
  input  logic [31:0]         sys_data,
  input  logic                clr_stats,
  input  logic                btn_next,
  output logic [CNT_BITS-1:0] disp_out,
  output logic [2:0]          disp_mode
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [CNT_BITS-1:0] total_cnt, cond_cnt, uncond_cnt, stall_cnt;
  logic [31:0]         sys_q, sys_d;
  logic [SYNC_N-1:0]   sync_q, sync_d;
  logic                prev_q, prev_d;
  logic                step;
  mode_e               mode_q, mode_d;
  logic [CNT_BITS-1:0] disp_q, disp_d;

  stat_counter #(.CNT_BITS(CNT_BITS)) u_total (
    .clk(clk), .rst(rst), .en(pcen), .clr(clr_stats), .count(total_cnt)
  );

  stat_counter #(.CNT_BITS(CNT_BITS)) u_cond (
    .clk(clk), .rst(rst), .en(pcen & branch_taken), .clr(clr_stats), .count(cond_cnt)
  );

  stat_counter #(.CNT_BITS(CNT_BITS)) u_uncond (
    .clk(clk), .rst(rst), .en(pcen & jmp), .clr(clr_stats), .count(uncond_cnt)
  );

  stat_counter #(.CNT_BITS(CNT_BITS)) u_stall (
    .clk(clk), .rst(rst), .en(pcen & bubble), .clr(clr_stats), .count(stall_cnt)
  );

  assign step = sync_q[SYNC_N-1] & ~prev_q;

  always_comb begin
    sys_d  = sys_show ? sys_data : sys_q;
    sync_d = {sync_q[SYNC_N-2:0], btn_next};
    prev_d = sync_q[SYNC_N-1];
  end

  // Out-of-range encodings recover to SHOW_SYS without waiting for a press.
  always_comb begin
    mode_d = mode_q;
    if (int'(mode_q) >= MODE_COUNT) mode_d = SHOW_SYS;
    else if (step)                  mode_d = next_mode(mode_q);
  end

  always_comb begin
    disp_d = '0;
    case (mode_q)
      SHOW_SYS:    disp_d = CNT_BITS'(sys_q);
      SHOW_TOTAL:  disp_d = total_cnt;
      SHOW_COND:   disp_d = cond_cnt;
      SHOW_UNCOND: disp_d = uncond_cnt;
      SHOW_STALL:  disp_d = stall_cnt;
      default:     disp_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sys_q  <= '0;
      sync_q <= '0;
      prev_q <= 1'b0;
      mode_q <= SHOW_SYS;
      disp_q <= '0;
    end else begin
      sys_q  <= sys_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      mode_q <= mode_d;
      disp_q <= disp_d;
    end
  end

  assign disp_out  = disp_q;
  assign disp_mode = mode_q;

endmodule

// File: tb/tb_pipeline_stat_monitor.sv
// Randomised and directed bench for pipeline_stat_monitor against a cycle-level
// behavioural model; a 4-bit instance shares the stimulus to exercise wrap.
module tb_pipeline_stat_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcen = 1'b0, jmp = 1'b0, branchTaken = 1'b0, bubble = 1'b0;
  logic        sysShow = 1'b0;
  logic [31:0] sysData = '0;
  logic        clrStats = 1'b0;
  logic        btnNext = 1'b0;
  logic [31:0] dispOut;
  logic [2:0]  dispMode;
  logic [3:0]  dispOut4;
  logic [2:0]  dispMode4;

  int checks = 0;
  int errors = 0;

  logic [31:0] totalM = '0, condM = '0, uncondM = '0, stallM = '0, sysM = '0, dispM = '0;
  int          modeM = 0;
  logic        p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;

  pipeline_stat_monitor dut (
    .clk(clk), .rst(rst), .pcen(pcen), .jmp(jmp), .branch_taken(branchTaken),
    .bubble(bubble), .sys_show(sysShow), .sys_data(sysData), .clr_stats(clrStats),
    .btn_next(btnNext), .disp_out(dispOut), .disp_mode(dispMode)
  );

  pipeline_stat_monitor #(.CNT_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .pcen(pcen), .jmp(jmp), .branch_taken(branchTaken),
    .bubble(bubble), .sys_show(sysShow), .sys_data(sysData), .clr_stats(clrStats),
    .btn_next(btnNext), .disp_out(dispOut4), .disp_mode(dispMode4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic j, input logic b, input logic bu,
                               input logic ss, input logic [31:0] sd, input logic cs,
                               input logic bt);
    @(negedge clk);
    pcen = p; jmp = j; branchTaken = b; bubble = bu;
    sysShow = ss; sysData = sd; clrStats = cs; btnNext = bt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic press();
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 1);
    idle(4);
  endtask

  // Reference model: a press is seen two edges after the raw button rises and
  // the displayed word lags the selected source by one edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      totalM = '0; condM = '0; uncondM = '0; stallM = '0; sysM = '0; dispM = '0;
      modeM = 0; p1 = 0; p2 = 0; p3 = 0;
    end else begin
      logic adv;
      case (modeM)
        0: dispM = sysM;
        1: dispM = totalM;
        2: dispM = condM;
        3: dispM = uncondM;
        default: dispM = stallM;
      endcase
      adv = p2 & ~p3;
      p3 = p2; p2 = p1; p1 = btnNext;
      if (clrStats) begin
        totalM = '0; condM = '0; uncondM = '0; stallM = '0;
      end else if (pcen) begin
        totalM  = totalM + 1;
        condM   = condM + (branchTaken ? 1 : 0);
        uncondM = uncondM + (jmp ? 1 : 0);
        stallM  = stallM + (bubble ? 1 : 0);
      end
      if (sysShow) sysM = sysData;
      if (adv) modeM = (modeM + 1) % 5;
    end
  end

  always @(negedge clk) begin
    checkOutput("dispOut", dispOut, dispM);
    checkOutput("dispMode", {29'b0, dispMode}, {29'b0, 3'(modeM)});
    checkOutput("dispOut4", {28'b0, dispOut4}, {28'b0, dispM[3:0]});
  end

  initial begin
    logic btnR;
    idle(2);
    rst = 1'b0;
    checkOutput("resetDisp", dispOut, 32'h0);
    checkOutput("resetMode", {29'b0, dispMode}, 32'h0);

    for (int c = 1; c <= 10; c++)
      applyStimulus(1, (c == 3 || c == 7), (c == 5), 0, 0, 32'h0, 0, 0);
    idle(1);
    checkOutput("modelTotal", totalM, 32'd10);
    checkOutput("modelUncond", uncondM, 32'd2);
    checkOutput("modelCond", condM, 32'd1);
    checkOutput("modelStall", stallM, 32'd0);
    press();
    checkOutput("showTotal", dispOut, 32'h0000000A);
    press();
    checkOutput("showCond", dispOut, 32'h00000001);
    press();
    checkOutput("showUncond", dispOut, 32'h00000002);

    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 1, 0, 32'h0, 0, 0);
    idle(2);
    checkOutput("haltedUncond", dispOut, 32'h00000002);
    applyStimulus(0, 0, 0, 0, 1, 32'h12345678, 0, 0);
    idle(1);
    press();
    press();
    checkOutput("sysShown", dispOut, 32'h12345678);

    applyStimulus(1, 0, 0, 1, 0, 32'h0, 1, 0);
    idle(2);
    checkOutput("clrTotal", totalM, 32'h0);
    checkOutput("clrModeKept", {29'b0, dispMode}, 32'h0);
    checkOutput("clrSysKept", dispOut, 32'h12345678);

    for (int i = 1; i <= 20; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 1);
      if (i == 3) checkOutput("heldBeforeStep", {29'b0, dispMode}, 32'h0);
      if (i == 4) checkOutput("heldStepEdge3", {29'b0, dispMode}, 32'h1);
    end
    idle(3);
    checkOutput("heldOneStep", {29'b0, dispMode}, 32'h1);
    for (int i = 0; i < 5; i++) press();
    checkOutput("fivePresses", {29'b0, dispMode}, 32'h1);

    applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 0);
    for (int i = 0; i < 17; i++) applyStimulus(1, 0, 0, 0, 0, 32'h0, 0, 0);
    idle(2);
    checkOutput("wrap4", {28'b0, dispOut4}, 32'h1);
    checkOutput("noWrap32", dispOut, 32'h11);

    press();
    press();
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncRstDisp", dispOut, 32'h0);
    checkOutput("asyncRstMode", {29'b0, dispMode}, 32'h0);
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 32'h0, 0, 0);
    press();
    checkOutput("resumeTotal", dispOut, 32'h3);

    btnR = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) btnR = ~btnR;
      applyStimulus(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 9) == 0), $urandom(),
                    1'($urandom_range(0, 40) == 0), btnR);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
